// File: rtl/imem_resp.sv
// Instruction-memory responder: accepts word fetches over valid/ready and returns the
// instruction after WAIT_CYCLES wait states, flagging misaligned or out-of-range addresses.
module imem_resp #(
    parameter int          ADDR_W      = 10,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ERR_INST    = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_addr,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_inst,
    output logic        o_rsp_err,
    input  logic        i_prog_we,
    input  logic [31:0] i_prog_addr,
    input  logic [31:0] i_prog_wdata
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            r_state;
    logic       [3:0]  r_cnt;
    logic       [31:0] r_addr;
    logic              r_live;
    logic       [31:0] r_mem [DEPTH];

    logic              w_accept;
    logic       [31:0] w_cap_addr;
    logic              w_cap_err;
    logic       [31:0] w_cap_inst;
    logic              w_unused;

    // Misalignment and range both map to the same error response, so one flag suffices.
    function automatic logic addr_bad(input logic [31:0] a);
        addr_bad = (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'd0);
    endfunction

    assign w_unused = ^{i_prog_addr[31:ADDR_W+2], i_prog_addr[1:0]};

    // r_live keeps req_ready low until the first edge after reset release.
    assign o_req_ready = ((r_state == S_IDLE) && r_live) ||
                         ((r_state == S_RESP) && i_rsp_ready);
    assign w_accept    = i_req_valid && o_req_ready;

    // Response data source: the live request address when there are no wait states.
    always_comb begin
        w_cap_addr = (WAIT_CYCLES == 0) ? i_req_addr : r_addr;
        if (addr_bad(w_cap_addr)) begin
            w_cap_err  = 1'b1;
            w_cap_inst = ERR_INST;
        end else begin
            w_cap_err  = 1'b0;
            w_cap_inst = r_mem[w_cap_addr[ADDR_W+1:2]];
        end
    end

    // Program port; no reset so contents survive rst_n, and a same-edge capture sees old data.
    always_ff @(posedge clk) begin
        if (i_prog_we) begin
            r_mem[i_prog_addr[ADDR_W+1:2]] <= i_prog_wdata;
        end
    end

    // Fetch FSM with registered response outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= 4'd0;
            r_addr      <= 32'd0;
            r_live      <= 1'b0;
            o_rsp_valid <= 1'b0;
            o_rsp_inst  <= 32'd0;
            o_rsp_err   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_addr <= i_req_addr;
                        if (WAIT_CYCLES == 0) begin
                            r_state     <= S_RESP;
                            o_rsp_valid <= 1'b1;
                            o_rsp_inst  <= w_cap_inst;
                            o_rsp_err   <= w_cap_err;
                        end else begin
                            r_state <= S_WAIT;
                            r_cnt   <= WAIT_INIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state     <= S_RESP;
                        o_rsp_valid <= 1'b1;
                        o_rsp_inst  <= w_cap_inst;
                        o_rsp_err   <= w_cap_err;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    if (i_rsp_ready) begin
                        if (i_req_valid) begin
                            r_addr <= i_req_addr;
                            if (WAIT_CYCLES == 0) begin
                                o_rsp_valid <= 1'b1;
                                o_rsp_inst  <= w_cap_inst;
                                o_rsp_err   <= w_cap_err;
                            end else begin
                                r_state     <= S_WAIT;
                                r_cnt       <= WAIT_INIT;
                                o_rsp_valid <= 1'b0;
                            end
                        end else begin
                            r_state     <= S_IDLE;
                            o_rsp_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    o_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp: one instance with one wait state, one with none.
module tb_imem_resp;

    logic        clk;
    logic        rst_n;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_wdata;

    logic        a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [31:0] a_req_addr, a_rsp_inst;
    logic        b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready, b_rsp_err;
    logic [31:0] b_req_addr, b_rsp_inst;

    int n_pass;
    int n_total;

    logic [31:0] pw [4];

    imem_resp #(.ADDR_W(10), .WAIT_CYCLES(1), .ERR_INST(32'h00000013)) u_w1 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_addr(a_req_addr),
        .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready),
        .o_rsp_inst(a_rsp_inst), .o_rsp_err(a_rsp_err),
        .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_wdata(prog_wdata)
    );

    imem_resp #(.ADDR_W(10), .WAIT_CYCLES(0), .ERR_INST(32'h00000013)) u_w0 (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_addr(b_req_addr),
        .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
        .o_rsp_inst(b_rsp_inst), .o_rsp_err(b_rsp_err),
        .i_prog_we(prog_we), .i_prog_addr(prog_addr), .i_prog_wdata(prog_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", n_pass, n_total);
        $fatal(1);
    end

    task automatic prog(input logic [31:0] addr, input logic [31:0] data);
        prog_we = 1'b1; prog_addr = addr; prog_wdata = data;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    // Single fetch on the one-wait-state instance; called at a negedge with the FSM idle.
    task automatic fetch_a(input logic [31:0] addr, output logic [31:0] inst,
                           output logic err, output int lat);
        a_rsp_ready = 1'b0; a_req_valid = 1'b1; a_req_addr = addr;
        @(negedge clk);
        a_req_valid = 1'b0;
        lat = 1;
        while (!a_rsp_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        if (!a_rsp_valid) lat = 99;
        inst = a_rsp_inst; err = a_rsp_err;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        n_total++; if (a_req_ready !== 1'b0) $display("FAIL rst_ready got %b exp 0", a_req_ready); else n_pass++;
        n_total++; if (a_rsp_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", a_rsp_valid); else n_pass++;
        n_total++; if (a_rsp_inst !== 32'd0) $display("FAIL rst_inst got %h exp 0", a_rsp_inst); else n_pass++;
        n_total++; if (a_rsp_err !== 1'b0) $display("FAIL rst_err got %b exp 0", a_rsp_err); else n_pass++;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_total++; if (a_req_ready !== 1'b1) $display("FAIL post_rst_ready_a got %b exp 1", a_req_ready); else n_pass++;
        n_total++; if (b_req_ready !== 1'b1) $display("FAIL post_rst_ready_b got %b exp 1", b_req_ready); else n_pass++;
    endtask

    task automatic test_fetch_seq;
        logic [31:0] inst;
        logic        err;
        int          lat;
        for (int i = 0; i < 4; i++) prog(32'(i * 4), pw[i]);
        for (int i = 0; i < 4; i++) begin
            fetch_a(32'(i * 4), inst, err, lat);
            n_total++; if (inst !== pw[i]) $display("FAIL seq_inst[%0d] got %h exp %h", i, inst, pw[i]); else n_pass++;
            n_total++; if (lat !== 2) $display("FAIL seq_lat[%0d] got %0d exp 2", i, lat); else n_pass++;
            n_total++; if (err !== 1'b0) $display("FAIL seq_err[%0d] got %b exp 0", i, err); else n_pass++;
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] inst;
        logic        err;
        int          lat;
        a_rsp_ready = 1'b0; a_req_valid = 1'b1; a_req_addr = 32'h4;
        @(negedge clk);
        a_req_valid = 1'b0;
        n_total++; if (a_rsp_valid !== 1'b0) $display("FAIL mid_wait_valid got %b exp 0", a_rsp_valid); else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_total++; if (a_rsp_valid !== 1'b0) $display("FAIL mid_rst_valid got %b exp 0", a_rsp_valid); else n_pass++;
        n_total++; if (a_rsp_inst !== 32'd0) $display("FAIL mid_rst_inst got %h exp 0", a_rsp_inst); else n_pass++;
        n_total++; if (a_req_ready !== 1'b0) $display("FAIL mid_rst_ready got %b exp 0", a_req_ready); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_total++; if (a_rsp_valid !== 1'b0) $display("FAIL mid_dropped_valid got %b exp 0", a_rsp_valid); else n_pass++;
        n_total++; if (a_req_ready !== 1'b1) $display("FAIL mid_idle_ready got %b exp 1", a_req_ready); else n_pass++;
        fetch_a(32'h0, inst, err, lat);
        n_total++; if (inst !== pw[0]) $display("FAIL mid_mem0 got %h exp %h", inst, pw[0]); else n_pass++;
    endtask

    task automatic test_stream_w0;
        b_rsp_ready = 1'b1; b_req_valid = 1'b1; b_req_addr = 32'h0;
        for (int k = 0; k < 4; k++) begin
            n_total++; if (b_req_ready !== 1'b1) $display("FAIL stream_ready[%0d] got %b exp 1", k, b_req_ready); else n_pass++;
            @(negedge clk);
            n_total++; if (b_rsp_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b exp 1", k, b_rsp_valid); else n_pass++;
            n_total++; if (b_rsp_inst !== pw[k]) $display("FAIL stream_inst[%0d] got %h exp %h", k, b_rsp_inst, pw[k]); else n_pass++;
            if (k < 3) b_req_addr = 32'((k + 1) * 4);
            else       b_req_valid = 1'b0;
        end
        @(negedge clk);
        n_total++; if (b_rsp_valid !== 1'b0) $display("FAIL stream_end_valid got %b exp 0", b_rsp_valid); else n_pass++;
        b_rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        a_rsp_ready = 1'b0; a_req_valid = 1'b1; a_req_addr = 32'h4;
        @(negedge clk);
        a_req_addr = 32'h8;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            n_total++; if (a_rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b exp 1", i, a_rsp_valid); else n_pass++;
            n_total++; if (a_rsp_inst !== pw[1]) $display("FAIL bp_inst[%0d] got %h exp %h", i, a_rsp_inst, pw[1]); else n_pass++;
            n_total++; if (a_req_ready !== 1'b0) $display("FAIL bp_ready[%0d] got %b exp 0", i, a_req_ready); else n_pass++;
            @(negedge clk);
        end
        a_rsp_ready = 1'b1;
        #1;
        n_total++; if (a_req_ready !== 1'b1) $display("FAIL bp_pipe_ready got %b exp 1", a_req_ready); else n_pass++;
        @(negedge clk);
        a_req_valid = 1'b0; a_rsp_ready = 1'b0;
        n_total++; if (a_rsp_valid !== 1'b0) $display("FAIL bp_pipe_wait got %b exp 0", a_rsp_valid); else n_pass++;
        @(negedge clk);
        n_total++; if (a_rsp_inst !== pw[2]) $display("FAIL bp_pipe_inst got %h exp %h", a_rsp_inst, pw[2]); else n_pass++;
        n_total++; if (a_rsp_valid !== 1'b1) $display("FAIL bp_pipe_valid got %b exp 1", a_rsp_valid); else n_pass++;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
        n_total++; if (a_rsp_valid !== 1'b0) $display("FAIL bp_idle_valid got %b exp 0", a_rsp_valid); else n_pass++;
    endtask

    task automatic test_errors;
        logic [31:0] inst;
        logic        err;
        int          lat;
        prog(32'hFFC, 32'hCAFEF00D);
        fetch_a(32'h2, inst, err, lat);
        n_total++; if (err !== 1'b1) $display("FAIL err_mis got %b exp 1", err); else n_pass++;
        n_total++; if (inst !== 32'h00000013) $display("FAIL err_mis_inst got %h exp 00000013", inst); else n_pass++;
        fetch_a(32'h1000, inst, err, lat);
        n_total++; if (err !== 1'b1) $display("FAIL err_range got %b exp 1", err); else n_pass++;
        n_total++; if (inst !== 32'h00000013) $display("FAIL err_range_inst got %h exp 00000013", inst); else n_pass++;
        fetch_a(32'h80000000, inst, err, lat);
        n_total++; if (err !== 1'b1) $display("FAIL err_msb got %b exp 1", err); else n_pass++;
        fetch_a(32'hFFC, inst, err, lat);
        n_total++; if (err !== 1'b0) $display("FAIL last_word_err got %b exp 0", err); else n_pass++;
        n_total++; if (inst !== 32'hCAFEF00D) $display("FAIL last_word_inst got %h exp cafef00d", inst); else n_pass++;
    endtask

    task automatic test_same_edge;
        logic [31:0] inst;
        logic        err;
        int          lat;
        prog(32'h14, 32'h11111111);
        a_rsp_ready = 1'b0; a_req_valid = 1'b1; a_req_addr = 32'h14;
        @(negedge clk);
        a_req_valid = 1'b0;
        prog_we = 1'b1; prog_addr = 32'h14; prog_wdata = 32'hDEADBEEF;
        @(negedge clk);
        prog_we = 1'b0;
        n_total++; if (a_rsp_inst !== 32'h11111111) $display("FAIL same_edge_old got %h exp 11111111", a_rsp_inst); else n_pass++;
        a_rsp_ready = 1'b1;
        @(negedge clk);
        a_rsp_ready = 1'b0;
        fetch_a(32'h14, inst, err, lat);
        n_total++; if (inst !== 32'hDEADBEEF) $display("FAIL same_edge_new got %h exp deadbeef", inst); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        pw[0] = 32'h00500093; pw[1] = 32'h00108113; pw[2] = 32'h002081B3; pw[3] = 32'h0000006F;
        prog_we = 1'b0; prog_addr = 32'd0; prog_wdata = 32'd0;
        a_req_valid = 1'b0; a_req_addr = 32'd0; a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_addr = 32'd0; b_rsp_ready = 1'b0;
        test_reset();
        test_fetch_seq();
        test_reset_mid();
        test_stream_w0();
        test_backpressure();
        test_errors();
        test_same_edge();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
